// File: rtl/regfile_dump.sv
// Debug dump of the register file test port as addr/data beats on a valid/ready stream.
// Latency: start -> FETCH next cycle -> first out_valid the cycle after; 2 cycles/word minimum.
// Backpressure: beat fields hold while out_valid && !out_ready. Optional REGFILE_DUMP_CHECKSUM_EN adds an XOR checksum beat.
module regfile_dump #(
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  test_addr,
    input  logic [31:0] test_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        out_last
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, FETCH, SEND, CHK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, SEND, DONE} state_t;
`endif

    state_t     state;
    state_t     state_nxt;
    logic [4:0] ptr;
    logic       hs;
    logic       at_last;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [31:0] acc;
`endif

    assign hs      = out_valid && out_ready;
    assign at_last = (ptr == LAST_IDX);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        test_addr = 5'd0;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                busy      = 1'b1;
                test_addr = ptr;
                state_nxt = SEND;
            end
            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (hs) begin
                    if (!at_last) state_nxt = FETCH;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    else          state_nxt = CHK;
`else
                    else          state_nxt = DONE;
`endif
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            CHK: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (hs) state_nxt = DONE;
            end
`endif
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat registers only load in FETCH (and on the checksum turn), so they
    // are naturally stable for the whole SEND/CHK stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= FIRST_IDX;
            out_addr <= 5'd0;
            out_data <= 32'd0;
            out_last <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            acc      <= 32'd0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    ptr <= FIRST_IDX;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    if (start) acc <= 32'd0;
`endif
                end
                FETCH: begin
                    out_addr <= ptr;
                    out_data <= test_data;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    out_last <= 1'b0;
`else
                    out_last <= at_last;
`endif
                end
                SEND: begin
                    if (hs) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        acc <= acc ^ out_data;
                        if (at_last) begin
                            // checksum beat includes the word handshaking right now
                            out_addr <= 5'd0;
                            out_data <= acc ^ out_data;
                            out_last <= 1'b1;
                        end
`endif
                        if (!at_last) ptr <= ptr + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: scenario table of full dumps against a register-file model,
// plus hand sequences for reset-state and mid-dump reset.
module tb_regfile_dump;

    localparam int FIRST = 1;
    localparam int LAST  = 31;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done;
    logic [4:0]  test_addr;
    logic [31:0] test_data;
    logic        out_valid, out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;

    logic [31:0] rf [32];

    assign test_data = (test_addr == 5'd0) ? 32'd0 : rf[test_addr];

    always #5 clk = ~clk;

    regfile_dump #(.FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .test_addr(test_addr), .test_data(test_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        string       name;
        int          rmod;     // out_ready high one cycle in rmod
        bit          wr;       // overwrite rf[waddr] when test_addr == wtrig
        logic [4:0]  wtrig;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        bit          restart;  // re-pulse start mid-dump
    } scen_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload();
        for (int k = 0; k < 32; k++) rf[k] = 32'(k) * 32'h01010101;
    endtask

    scen_t sc [4];
    beat_t exp_q [$];

    initial begin
        beat_t  prev;
        bit     have_prev;
        bit     written;
        bit     rdy;
        bit     found;
        int     cyc, nbeats, ndone, done_cyc, stall_bad;
        logic [31:0] acc;
        logic [31:0] d;

        sc[0] = '{"ready_hi",   1, 1'b0, 5'd0, 5'd0, 32'h0,        1'b0};
        sc[1] = '{"ready_1of3", 3, 1'b0, 5'd0, 5'd0, 32'h0,        1'b0};
        sc[2] = '{"live_write", 1, 1'b1, 5'd3, 5'd5, 32'hDEADBEEF, 1'b0};
        sc[3] = '{"restart",    2, 1'b0, 5'd0, 5'd0, 32'h0,        1'b1};

        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        preload();
        #1;
        chk("rst_ctrl", {busy, done, out_valid, out_last}, 4'b0000);
        chk("rst_addr", {test_addr, out_addr}, 10'd0);
        chk("rst_data", out_data, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int si = 0; si < 4; si++) begin
            preload();
            exp_q.delete();
            acc = 32'd0;
            for (int k = FIRST; k <= LAST; k++) begin
                d = (sc[si].wr && k == int'(sc[si].waddr)) ? sc[si].wdata : 32'(k) * 32'h01010101;
                acc ^= d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                exp_q.push_back('{5'(k), d, 1'b0});
`else
                exp_q.push_back('{5'(k), d, k == LAST});
`endif
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            exp_q.push_back('{5'd0, acc, 1'b1});
`endif
            out_ready = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 1; nbeats = 0; ndone = 0; done_cyc = -1; stall_bad = 0;
            have_prev = 1'b0; written = 1'b0;
            while (cyc < 400 && (done_cyc < 0 || cyc < done_cyc + 3)) begin
                if (si == 0 && cyc == 1) chk("lat_fetch", {busy, out_valid}, 2'b10);
                if (si == 0 && cyc == 2) chk("lat_valid", {busy, out_valid}, 2'b11);
                if (done) begin
                    ndone++;
                    if (done_cyc < 0) done_cyc = cyc;
                end
                if (have_prev && !out_valid) stall_bad++;
                if (have_prev && out_valid && {out_addr, out_data, out_last} != {prev.a, prev.d, prev.l})
                    stall_bad++;
                if (sc[si].wr && !written && test_addr == sc[si].wtrig) begin
                    rf[sc[si].waddr] = sc[si].wdata;
                    written = 1'b1;
                end
                start = sc[si].restart && (cyc == 20 || cyc == 41);
                rdy = (cyc % sc[si].rmod) == 0;
                out_ready = rdy;
                if (out_valid && rdy) begin
                    if (nbeats < exp_q.size())
                        chk($sformatf("%s_beat%0d", sc[si].name, nbeats),
                            {out_addr, out_data, out_last},
                            {exp_q[nbeats].a, exp_q[nbeats].d, exp_q[nbeats].l});
                    nbeats++;
                    have_prev = 1'b0;
                end else if (out_valid) begin
                    prev = '{out_addr, out_data, out_last};
                    have_prev = 1'b1;
                end else begin
                    have_prev = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            out_ready = 1'b0;
            chk({sc[si].name, "_nbeats"}, nbeats, exp_q.size());
            chk({sc[si].name, "_ndone"}, ndone, 1);
            chk({sc[si].name, "_stall"}, stall_bad, 0);
            chk({sc[si].name, "_idle"}, {busy, out_valid}, 2'b00);
`ifndef REGFILE_DUMP_CHECKSUM_EN
            // DONE is the state after the 63rd edge following the sampling edge
            if (si == 0) chk("done_cycle", done_cyc, 63);
`endif
            @(negedge clk);
        end

        // Mid-dump reset while beat for register 10 is stalled in SEND
        preload();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (out_valid && out_addr == 5'd10) begin
                found = 1'b1;
                out_ready = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        chk("reach_addr10", found, 1'b1);
        @(negedge clk);
        chk("stall_addr10", {out_valid, out_addr}, {1'b1, 5'd10});
        reset = 1'b1;
        #1;
        chk("arst_ctrl", {busy, done, out_valid, out_last}, 4'b0000);
        chk("arst_addr", {test_addr, out_addr}, 10'd0);
        chk("arst_data", out_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {busy, done, out_valid}, 3'b000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (out_valid) found = 1'b1;
            else @(negedge clk);
        end
        chk("restart_valid", found, 1'b1);
        chk("restart_beat", {out_addr, out_data}, {5'(FIRST), 32'(FIRST) * 32'h01010101});
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        chk("restart_done", found, 1'b1);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
